load_unit: RTL and testbench



---
 rtl/load_pkg.sv | 36 +++
 rtl/load_ext.sv | 38 +++
 rtl/load_unit.sv | 122 ++++++++++++
 tb/tb_load_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared definitions for the load unit: opcodes, FSM states, memory geometry
// and the access fault rule used at request acceptance.
package load_pkg;

    localparam int DM_WORDS_DEFAULT = 2048;
    localparam int TIMEOUT_DEFAULT  = 16;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } load_state_t;

    // An access faults when misaligned for its width, beyond the data memory,
    // or when the opcode is not a supported load.
    function automatic logic load_fault(input logic [5:0]  op,
                                        input logic [31:0] addr,
                                        input logic [31:0] limit);
        logic fault;
        fault = 1'b0;
        case (op)
            OP_LW:          fault = (addr[1:0] != 2'b00) || (addr >= limit);
            OP_LH, OP_LHU:  fault = addr[0] || (addr >= limit);
            OP_LB, OP_LBU:  fault = (addr >= limit);
            default:        fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational byte/half/word selection and extension of a memory word;
// kept standalone so the bypass path can reuse it.
module load_ext
    import load_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'b00:   byte_sel = word[7:0];
            2'b01:   byte_sel = word[15:8];
            2'b10:   byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = 32'd0;
        case (op)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'd0, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'd0, half_sel};
            OP_LW:   result = word;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: accepts one load at a time, checks for address faults, reads the
// data memory with a bounded wait and returns the extended result.
module load_unit
    import load_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEFAULT,
    parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [31:0]                 ins,
    input  logic [31:0]                 addr,
    input  logic                        flush,
    output logic                        mem_rd_en,
    output logic [$clog2(DM_WORDS)-1:0] mem_addr,
    input  logic [31:0]                 mem_rdata,
    input  logic                        mem_rvalid,
    output logic                        rsp_valid,
    output logic [31:0]                 rsp_data,
    output logic                        rsp_exc,
    input  logic                        rsp_ready
);

    localparam int          MA_W       = $clog2(DM_WORDS);
    localparam int          CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(DM_WORDS * 4);

    load_state_t      state;
    logic [5:0]       lat_op;
    logic [1:0]       lat_lane;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      ext_result;
    logic             accept_fault;
    logic             unused_ins;

    assign unused_ins = ^ins[25:0];

    // Readiness also drops while reset is held so nothing is offered during reset.
    assign req_ready    = (state == IDLE) && !flush && reset;
    assign accept_fault = load_fault(ins[31:26], addr, ADDR_LIMIT);

    load_ext u_ext (
        .op     (lat_op),
        .lane   (lat_lane),
        .word   (mem_rdata),
        .result (ext_result)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            lat_op    <= 6'd0;
            lat_lane  <= 2'd0;
            wait_cnt  <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_exc   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_rd_en <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_exc   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_rd_en <= 1'b0;
                    if (req_valid) begin
                        lat_op   <= ins[31:26];
                        lat_lane <= addr[1:0];
                        mem_addr <= addr[MA_W+1:2];
                        wait_cnt <= '0;
                        if (accept_fault) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_exc   <= 1'b1;
                            rsp_data  <= 32'd0;
                        end else begin
                            state     <= READ;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                // The strobe lasts one cycle; rvalid counts from that same cycle.
                READ: begin
                    mem_rd_en <= 1'b0;
                    if (mem_rvalid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_exc   <= 1'b0;
                        rsp_data  <= ext_result;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_exc   <= 1'b1;
                        rsp_data  <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    mem_rd_en <= 1'b0;
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_rd_en <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Randomized scoreboard bench for load_unit: stimulus pushes expected
// responses, a negedge monitor pops them on every response handshake.
module tb_load_unit;

    localparam int TIMEOUT  = 16;
    localparam int DM_WORDS = 2048;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LW  = 6'b100011;

    typedef struct {
        logic [31:0] data;
        logic        exc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] ins;
    logic [31:0] addr;
    logic        flush;
    logic        mem_rd_en;
    logic [10:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_exc;
    logic        rsp_ready;

    int   checks;
    int   passes;
    exp_t sb[$];

    logic        held;
    logic [31:0] held_data;
    logic        held_exc;

    load_unit #(.DM_WORDS(DM_WORDS), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .ins        (ins),
        .addr       (addr),
        .flush      (flush),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_exc    (rsp_exc),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required)
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        else
            passes++;
    endtask

    // Reference rules written directly from the load definitions.
    function automatic logic model_fault(input logic [5:0] op, input logic [31:0] a);
        int unsigned limit;
        limit = DM_WORDS * 4;
        if (a >= limit) return 1'b1;
        if (op == LW) return (a % 4) != 0;
        if (op == LH || op == LHU) return (a % 2) != 0;
        if (op == LB || op == LBU) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_data(input logic [5:0] op, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (a % 4))) & 32'h0000_00FF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
        case (op)
            LB:      return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            LBU:     return b;
            LH:      return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    // Response monitor: compares on handshake and checks that a stalled response holds.
    always @(negedge clk) begin
        if (reset && rsp_valid) begin
            if (held) begin
                checkOutput("rsp_data_stable", rsp_data, held_data);
                checkOutput("rsp_exc_stable", {31'd0, rsp_exc}, {31'd0, held_exc});
            end
            if (rsp_ready) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_rsp: got data %h exc %b, required no response",
                             rsp_data, rsp_exc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("rsp_data", rsp_data, e.data);
                    checkOutput("rsp_exc", {31'd0, rsp_exc}, {31'd0, e.exc});
                end
            end else begin
                held      = 1'b1;
                held_data = rsp_data;
                held_exc  = rsp_exc;
            end
        end else begin
            held = 1'b0;
        end
    end

    // One full load; dly<0 means memory never answers, rdy is extra stall cycles.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] w, input int dly, input int rdy);
        logic got;
        logic fault;
        int   exp_lat;
        int   lat;
        int   rd_cnt;
        int   rd_cyc;
        exp_t e;
        req_valid = 1'b1;
        ins       = {op, 26'($urandom)};
        addr      = a;
        got       = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput("req_ready_accept", {31'd0, got}, 32'd1);
        if (!got) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        ins       = $urandom;
        addr      = $urandom;
        fault     = model_fault(op, a);
        e.exc     = fault || (dly < 0);
        e.data    = e.exc ? 32'd0 : model_data(op, a, w);
        sb.push_back(e);
        exp_lat = fault ? 1 : (dly < 0 ? TIMEOUT + 1 : dly + 2);
        lat     = 0;
        rd_cnt  = 0;
        rd_cyc  = 0;
        for (int c = 1; c <= TIMEOUT + 6; c++) begin
            mem_rvalid = (dly >= 0) && (c == dly + 1) && !fault;
            mem_rdata  = mem_rvalid ? w : $urandom;
            @(negedge clk);
            if (mem_rd_en) begin
                rd_cnt++;
                rd_cyc = c;
            end
            if (c == 1 && !fault)
                checkOutput("mem_addr", {21'd0, mem_addr}, (a >> 2) & 32'h7FF);
            if (rsp_valid) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput("rsp_latency", lat, exp_lat);
        checkOutput("rd_en_count", rd_cnt, fault ? 0 : 1);
        if (!fault) checkOutput("rd_en_cycle", rd_cyc, 1);
        for (int k = 0; k <= rdy; k++) begin
            @(posedge clk); #1;
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready  = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        clk = 0; reset = 0; req_valid = 0; ins = 0; addr = 0; flush = 0;
        mem_rdata = 0; mem_rvalid = 0; rsp_ready = 0;
        checks = 0; passes = 0; held = 0; held_data = 0; held_exc = 0;

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rd_en", {31'd0, mem_rd_en}, 32'd0);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        checkOutput("req_ready_after_reset", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        applyStimulus(LB,  32'h0000_0003, 32'h80AB_CDEF, 0, 0);
        applyStimulus(LHU, 32'h0000_0102, 32'h9234_5678, 0, 1);
        applyStimulus(LH,  32'h0000_0102, 32'h9234_5678, 2, 0);
        applyStimulus(LW,  32'h0000_0006, 32'h1234_5678, 0, 0);
        applyStimulus(LW,  32'h0000_2000, 32'h1234_5678, 0, 0);
        applyStimulus(LW,  32'h0000_0010, 32'hDEAD_BEEF, -1, 5);
        applyStimulus(6'b000000, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);

        // Flush during the strobe cycle, late rvalid must be ignored.
        req_valid = 1; ins = {LW, 26'd0}; addr = 32'h0000_0044;
        @(negedge clk);
        checkOutput("flush_accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 0; flush = 1;
        @(negedge clk);
        checkOutput("flush_strobe", {31'd0, mem_rd_en}, 32'd1);
        @(posedge clk); #1;
        flush = 0; mem_rvalid = 1; mem_rdata = $urandom;
        @(negedge clk);
        checkOutput("flush_idle_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        mem_rvalid = 0;
        @(negedge clk);
        checkOutput("flush_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;

        // Flush overrides a request in IDLE.
        req_valid = 1; flush = 1; ins = {LW, 26'd0}; addr = 32'h0000_0040;
        @(negedge clk);
        checkOutput("flush_blocks_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        req_valid = 0; flush = 0;
        @(negedge clk);
        checkOutput("flush_no_strobe", {31'd0, mem_rd_en}, 32'd0);
        checkOutput("flush_still_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        applyStimulus(LBU, 32'h0000_0001, 32'h0000_F000, 0, 0);

        // Reset while a response is waiting.
        req_valid = 1; ins = {LW, 26'd0}; addr = 32'h0000_0020;
        @(posedge clk); #1;
        req_valid = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_rvalid = 0;
        @(negedge clk);
        checkOutput("pre_reset_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        checkOutput("mid_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("mid_reset_rsp_data", rsp_data, 32'd0);
        checkOutput("mid_reset_rsp_exc", {31'd0, rsp_exc}, 32'd0);
        checkOutput("mid_reset_mem_addr", {21'd0, mem_addr}, 32'd0);
        checkOutput("mid_reset_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1;
        @(negedge clk);
        checkOutput("post_reset_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        applyStimulus(LW, 32'h0000_0024, 32'h0BAD_C0DE, 1, 0);

        for (int n = 0; n < 40; n++) begin
            logic [5:0]  op;
            logic [31:0] a;
            int          sel;
            int          dly;
            sel = $urandom_range(0, 11);
            case (sel)
                0, 1:    op = LB;
                2, 3:    op = LBU;
                4, 5:    op = LH;
                6, 7:    op = LHU;
                8, 9, 10: op = LW;
                default: op = 6'($urandom);
            endcase
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DM_WORDS * 4 - 1));
            dly = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
            applyStimulus(op, a, $urandom, dly, $urandom_range(0, 2));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
